// File: rtl/nspi_frame_feeder.sv
// Frame sequencer for nspi_tx: fetches one frame of per-channel bytes from a synchronous
// RAM, hands each byte to the serialiser via start_tx/tx_finish and ends with a latch pulse.
module nspi_frame_feeder #(
  parameter int unsigned CHANNEL_NUMBER  = 2,
  parameter int unsigned SPI_SIZE        = 8,
  parameter int unsigned BYTES_PER_FRAME = 384,
  parameter int unsigned GAP_CYCLES      = 4,
  parameter int unsigned LATCH_CYCLES    = 16,
  localparam int unsigned ADDR_W = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               frame_start,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               mem_rd_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] mem_rdata,
  output logic [SPI_SIZE-1:0]                data_out [CHANNEL_NUMBER],
  output logic                               start_tx,
  input  logic                               tx_finish,
  output logic                               frame_latch
);

  localparam int unsigned CNT_MAX    = (GAP_CYCLES > LATCH_CYCLES) ? GAP_CYCLES : LATCH_CYCLES;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned LATCH_LAST = (LATCH_CYCLES > 0) ? LATCH_CYCLES - 1 : 0;
  localparam int unsigned LAST_IDX   = BYTES_PER_FRAME - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT_RD = 3'd2,
    S_SEND    = 3'd3,
    S_GAP     = 3'd4,
    S_LATCH   = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   byte_idx, byte_idx_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;

  logic                busy_d;
  logic                frame_done_d;
  logic                mem_rd_en_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                start_tx_d;
  logic                frame_latch_d;
  logic                load_data;

  // State, byte index and shared gap/latch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      byte_idx <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Next-state logic; the counter restarts from zero on every state change
  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    cnt_nxt      = '0;
    unique case (state)
      S_IDLE: begin
        // frame_done marks the final busy cycle, so a request there is dropped
        if (frame_start && !frame_done) begin
          state_nxt    = S_FETCH;
          byte_idx_nxt = '0;
        end
      end
      S_FETCH:   state_nxt = S_WAIT_RD;
      S_WAIT_RD: state_nxt = S_SEND;
      S_SEND: begin
        // start_tx is high only in the first SEND cycle; a finish there is stale
        if (tx_finish && !start_tx) begin
          if (byte_idx == ADDR_W'(LAST_IDX)) begin
            state_nxt = S_LATCH;
          end else begin
            byte_idx_nxt = byte_idx + 1'b1;
            state_nxt    = (GAP_CYCLES == 0) ? S_FETCH : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP_LAST)) state_nxt = S_FETCH;
        else                         cnt_nxt   = cnt + 1'b1;
      end
      S_LATCH: begin
        if (cnt == CNT_W'(LATCH_LAST)) state_nxt = S_IDLE;
        else                           cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    mem_rd_en_d   = (state_nxt == S_FETCH);
    mem_addr_d    = mem_rd_en_d ? byte_idx_nxt : mem_addr;
    start_tx_d    = (state_nxt == S_SEND) && (state != S_SEND);
    frame_latch_d = (state_nxt == S_LATCH);
    frame_done_d  = (state == S_LATCH) && (state_nxt == S_IDLE);
    busy_d        = (state_nxt != S_IDLE) || frame_done_d;
    load_data     = (state == S_WAIT_RD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      start_tx    <= 1'b0;
      frame_latch <= 1'b0;
    end else begin
      busy        <= busy_d;
      frame_done  <= frame_done_d;
      mem_rd_en   <= mem_rd_en_d;
      mem_addr    <= mem_addr_d;
      start_tx    <= start_tx_d;
      frame_latch <= frame_latch_d;
    end
  end

  // RAM word captured at the end of WAIT_RD and held for the whole SEND phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CHANNEL_NUMBER; c++) data_out[c] <= '0;
    end else if (load_data) begin
      for (int unsigned c = 0; c < CHANNEL_NUMBER; c++)
        data_out[c] <= mem_rdata[c*SPI_SIZE +: SPI_SIZE];
    end
  end

endmodule

// File: tb/tb_nspi_frame_feeder.sv
// Bench for nspi_frame_feeder: two instances (4-byte frame with gap, 1-byte frame without gap)
// driven through one shared stimulus path and checked against a frame-level reference.
module tb_nspi_frame_feeder;

  localparam int unsigned CH = 2;
  localparam int unsigned SW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus, steered to the selected instance
  logic        sel;
  logic        frame_start;
  logic        tx_finish;
  logic [15:0] mem_rdata;

  logic            fs_a, busy_a, done_a, rd_a, stx_a, fin_a, latch_a;
  logic [1:0]      addr_a;
  logic [SW-1:0]   dout_a [CH];
  logic            fs_b, busy_b, done_b, rd_b, stx_b, fin_b, latch_b;
  logic [0:0]      addr_b;
  logic [SW-1:0]   dout_b [CH];

  assign fs_a  = frame_start & ~sel;
  assign fin_a = tx_finish & ~sel;
  assign fs_b  = frame_start & sel;
  assign fin_b = tx_finish & sel;

  nspi_frame_feeder #(
    .CHANNEL_NUMBER(CH), .SPI_SIZE(SW), .BYTES_PER_FRAME(4), .GAP_CYCLES(4), .LATCH_CYCLES(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .busy(busy_a), .frame_done(done_a),
    .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(mem_rdata), .data_out(dout_a),
    .start_tx(stx_a), .tx_finish(fin_a), .frame_latch(latch_a)
  );

  nspi_frame_feeder #(
    .CHANNEL_NUMBER(CH), .SPI_SIZE(SW), .BYTES_PER_FRAME(1), .GAP_CYCLES(0), .LATCH_CYCLES(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .busy(busy_b), .frame_done(done_b),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(mem_rdata), .data_out(dout_b),
    .start_tx(stx_b), .tx_finish(fin_b), .frame_latch(latch_b)
  );

  logic        o_busy, o_done, o_rd, o_stx, o_latch;
  logic [15:0] o_addr, o_dout;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_rd    = sel ? rd_b    : rd_a;
  assign o_stx   = sel ? stx_b   : stx_a;
  assign o_latch = sel ? latch_b : latch_a;
  assign o_addr  = sel ? 16'(addr_b) : 16'(addr_a);
  assign o_dout  = sel ? {dout_b[1], dout_b[0]} : {dout_a[1], dout_a[0]};

  logic [15:0] ram [4];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"},  32'({o_busy, o_rd, o_stx, o_latch, o_done}), 0);
    check({tag, "_addr"}, 32'(o_addr), 0);
    check({tag, "_data"}, 32'(o_dout), 0);
  endtask

  // One frame on the selected instance, entered and left on a falling edge.
  // Reference: bytes leave in RAM order, finish->fetch spacing is gap+1 cycles,
  // latch spans lat cycles right after the last finish, then one frame_done.
  task automatic run_frame(input int fin_delay, input bit rand_delay, input bit poke,
                           input bit spurious, input bit abort);
    int bpf, gap, lat;
    int timer, t_fin, t_latch, n_start, n_fetch, n_latch, n_done, busy_drop, n_extra;
    bit rd_pending, aborted;
    logic [1:0] rd_addr;
    logic [15:0] exp_q [$];
    bpf = sel ? 1 : 4;
    gap = sel ? 0 : 4;
    lat = sel ? 3 : 16;
    exp_q = {};
    for (int i = 0; i < bpf; i++) exp_q.push_back(ram[i]);
    timer = 0; t_fin = -1; t_latch = -1; n_start = 0; n_fetch = 0; n_latch = 0;
    n_done = 0; busy_drop = 0; rd_pending = 1'b0; rd_addr = 2'd0; aborted = 1'b0;
    frame_start = 1'b1;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      frame_start = 1'b0;
      tx_finish   = 1'b0;
      // RAM model: word valid only during the cycle after the read strobe
      mem_rdata  = rd_pending ? ram[rd_addr] : 16'($urandom);
      rd_pending = o_rd;
      rd_addr    = o_addr[1:0];
      if (abort && !o_stx && n_start == 3 && timer > 0) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n   = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (!o_busy) busy_drop++;
      if (cyc == 1) begin
        check("lat_rd_en", 32'(o_rd), 1);
        check("lat_addr", 32'(o_addr), 0);
      end
      if (cyc == 3) check("lat_start_tx", 32'(o_stx), 1);
      if (o_rd) begin
        check("fetch_addr", 32'(o_addr), n_fetch);
        if (t_fin >= 0) check("gap_len", cyc - t_fin, gap + 1);
        n_fetch++;
      end
      if (o_stx) begin
        if (n_start < bpf) check("data_out", 32'(o_dout), 32'(exp_q[n_start]));
        n_start++;
        timer = rand_delay ? int'($urandom_range(1, 12)) : fin_delay;
        if (spurious) tx_finish = 1'b1;
        if (poke && n_start == 2) frame_start = 1'b1;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          if (n_start >= 1 && n_start <= bpf)
            check("data_hold", 32'(o_dout), 32'(exp_q[n_start-1]));
          tx_finish = 1'b1;
          t_fin     = cyc;
        end
      end
      if (o_latch) begin
        if (n_latch == 0) check("latch_start", cyc - t_fin, 1);
        n_latch++;
        t_latch = cyc;
      end
      if (o_done) begin
        n_done++;
        check("done_busy", 32'(o_busy), 1);
        check("done_latch_off", 32'(o_latch), 0);
        check("latch_to_done", cyc - t_latch, 1);
        check("n_start", n_start, bpf);
        check("n_latch", n_latch, lat);
        if (poke) frame_start = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      check("n_done", n_done, 1);
      check("busy_held", busy_drop, 0);
      n_extra = 0;
      repeat (gap + 30) begin
        @(negedge clk);
        frame_start = 1'b0;
        tx_finish   = 1'b0;
        if (o_rd || o_done || o_busy || o_stx || o_latch) n_extra++;
      end
      check("idle_after", n_extra, 0);
    end
  endtask

  initial begin
    int n_extra;
    rst_n       = 1'b0;
    sel         = 1'b0;
    frame_start = 1'b0;
    tx_finish   = 1'b0;
    mem_rdata   = 16'h0;
    ram[0] = 16'hF00F;
    ram[1] = 16'h2211;
    ram[2] = 16'h4433;
    ram[3] = 16'hCCBB;
    repeat (3) @(negedge clk);
    check_all_zero("reset_a");
    sel = 1'b1;
    #1 check_all_zero("reset_b");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed frame, finish 10 cycles after each start_tx
    run_frame(10, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stray tx_finish while idle
    tx_finish = 1'b1;
    n_extra   = 0;
    repeat (6) begin
      @(negedge clk);
      tx_finish = 1'b0;
      if (o_rd || o_busy || o_stx) n_extra++;
    end
    check("idle_tx_finish", n_extra, 0);

    // Requests during SEND and frame_done, plus stale finish in start_tx cycles
    for (int i = 0; i < 4; i++) ram[i] = 16'($urandom);
    run_frame(0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of byte 2, then a clean restart from address 0
    run_frame(10, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all_zero("post_rst");
    for (int i = 0; i < 4; i++) ram[i] = 16'($urandom);
    run_frame(0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Single-byte frame without gap
    sel = 1'b1;
    @(negedge clk);
    run_frame(5, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      ram[0] = 16'($urandom);
      run_frame(0, 1'b1, k == 1, k == 2, 1'b0);
    end

    // More randomized multi-byte frames
    sel = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) ram[i] = 16'($urandom);
      run_frame(0, 1'b1, 1'b0, k == 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
